s5378_bench: RTL and testbench
==============================

S5378_BENCH -- requirements
Module: s5378_bench

Interface
REQ-001 SHALL have port blif_clk_net, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port blif_reset_net, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports n3065gat..n3095gat and n3097gat..n3100gat, inputs, 1 bit each (35 total), forming bus I[34:0]: I[0]=n3065gat .. I[30]=n3095gat, I[31]=n3097gat, I[32]=n3098gat, I[33]=n3099gat, I[34]=n3100gat.
REQ-004 SHALL have ports n3104gat..n3152gat, outputs, 1 bit each (49 total), forming bus O[48:0] with O[k]=n(3104+k)gat.
REQ-005 SHALL have port test_se, input, 1 bit: scan enable (1=shift, 0=functional).
REQ-006 SHALL have port test_si1, input, 1 bit: scan-in of chain 1.
REQ-007 SHALL have port test_si2, input, 1 bit: scan-in of chain 2.
REQ-008 SHALL have port test_so1, output, 1 bit: scan-out of chain 1.
REQ-009 SHALL have port test_so2, output, 1 bit: scan-out of chain 2.
REQ-010 SHALL have no parameters and no other ports.

Function
REQ-011 SHALL contain exactly three state registers: R[34:0] (input capture), A[15:0] (accumulator), L[15:0] (LFSR); no other flops.
REQ-012 SHALL, in functional mode (test_se=0, reset low), load R <= I each edge.
REQ-013 SHALL, in functional mode, update A <= (A + R[15:0]) mod 2^16 when R[34]=1, else hold A; pre-edge R is used (one-cycle pipeline from I to A).
REQ-014 SHALL, in functional mode, shift L <= {L[14:0], L[15]^L[13]^L[12]^L[10]} when R[33]=1, else hold L; pre-edge R is used.
REQ-015 SHALL keep L at 0x0000 if it is ever scanned to 0x0000; no lock-up recovery.
REQ-016 SHALL drive O[15:0]=A and O[31:16]=L, combinationally from the registers.
REQ-017 SHALL drive O[46:32] = R[14:0] XOR R[29:15].
REQ-018 SHALL drive O[47] = XOR-reduction of R[34:0] (odd parity) and O[48] = 1 iff A = 0xFFFF.
REQ-019 SHALL, in scan mode (test_se=1, reset low), shift chain 1 as R <= {R[33:0], test_si1}, with test_so1 = R[34].
REQ-020 SHALL, in scan mode, shift chain 2 as the 32-bit concatenation C2={L,A}: C2 <= {C2[30:0], test_si2}, with test_so2 = L[15]; A[0] receives test_si2 and L[0] receives A[15].
REQ-021 SHALL ignore I entirely during scan mode; scan shift takes precedence over accumulation and LFSR stepping.
REQ-022 SHALL drive test_so1/test_so2 continuously from the register bits in both modes.

Reset
REQ-023 SHALL, on a rising edge with blif_reset_net=1, set R=0, A=0x0000 and L=0x0001, overriding test_se and all inputs.
REQ-024 SHALL therefore present after reset: O[15:0]=0x0000, O[31:16]=0x0001 (n3120gat=1), O[48:32]=0, test_so1=0, test_so2=0.
REQ-025 SHALL leave register contents undefined until the first reset edge; no asynchronous behaviour.

Verification
REQ-026 Reset: reset high one edge, any I/test_se -> O[15:0]=0x0000, O[31:16]=0x0001, O[48:32]=0, so1=so2=0.
REQ-027 Accumulate: after reset, test_se=0, hold I[34]=1, I[15:0]=0x0005, I[33]=0 -> edge1 A=0, edge2 A=0x0005, edge3 A=0x000A; L stays 0x0001.
REQ-028 Wrap: after reset, hold I[34]=1, I[15:0]=0xFFFF -> edge2 A=0xFFFF with O[48]=1; edge3 A=0xFFFE with O[48]=0.
REQ-029 LFSR: after reset, hold I[33]=1, I[34]=0 -> edge2 L=0x0002, edge3 L=0x0004; A stays 0.
REQ-030 Scan: test_se=1, shift 35 ones into test_si1 -> R=all ones, O[47]=1, O[46:32]=0; first 35 test_so1 bits equal the prior R from R[34] down to R[0]; 32 shifts on chain 2 unload L[15] first through A[0].
REQ-031 Reset mid-scan: reset high with test_se=1 during a shift -> reset values of REQ-024 on the next edge; shifting resumes afterward from that state.

Source files
------------

// File: rtl/s5378_bench.sv
// rtl/s5378_bench.sv - input-capture/accumulator/LFSR block with two scan chains
// Chain 1 is the capture register; chain 2 is {lfsr, acc}, so acc[15] feeds lfsr[0] when shifting.
module s5378_bench (
  input  logic blif_clk_net,
  input  logic blif_reset_net,
  input  logic n3065gat, n3066gat, n3067gat, n3068gat, n3069gat, n3070gat, n3071gat,
  input  logic n3072gat, n3073gat, n3074gat, n3075gat, n3076gat, n3077gat, n3078gat,
  input  logic n3079gat, n3080gat, n3081gat, n3082gat, n3083gat, n3084gat, n3085gat,
  input  logic n3086gat, n3087gat, n3088gat, n3089gat, n3090gat, n3091gat, n3092gat,
  input  logic n3093gat, n3094gat, n3095gat, n3097gat, n3098gat, n3099gat, n3100gat,
  output logic n3104gat, n3105gat, n3106gat, n3107gat, n3108gat, n3109gat, n3110gat,
  output logic n3111gat, n3112gat, n3113gat, n3114gat, n3115gat, n3116gat, n3117gat,
  output logic n3118gat, n3119gat, n3120gat, n3121gat, n3122gat, n3123gat, n3124gat,
  output logic n3125gat, n3126gat, n3127gat, n3128gat, n3129gat, n3130gat, n3131gat,
  output logic n3132gat, n3133gat, n3134gat, n3135gat, n3136gat, n3137gat, n3138gat,
  output logic n3139gat, n3140gat, n3141gat, n3142gat, n3143gat, n3144gat, n3145gat,
  output logic n3146gat, n3147gat, n3148gat, n3149gat, n3150gat, n3151gat, n3152gat,
  input  logic test_se,
  input  logic test_si1,
  input  logic test_si2,
  output logic test_so1,
  output logic test_so2
);

  logic [34:0] in_bus;
  logic [48:0] out_bus;
  logic [34:0] cap;
  logic [15:0] acc;
  logic [15:0] lfsr;

  assign in_bus = {n3100gat, n3099gat, n3098gat, n3097gat, n3095gat, n3094gat, n3093gat,
                   n3092gat, n3091gat, n3090gat, n3089gat, n3088gat, n3087gat, n3086gat,
                   n3085gat, n3084gat, n3083gat, n3082gat, n3081gat, n3080gat, n3079gat,
                   n3078gat, n3077gat, n3076gat, n3075gat, n3074gat, n3073gat, n3072gat,
                   n3071gat, n3070gat, n3069gat, n3068gat, n3067gat, n3066gat, n3065gat};

  // Scan shift wins over accumulate/step; an all-zero LFSR stays stuck by design.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      cap  <= '0;
      acc  <= 16'h0000;
      lfsr <= 16'h0001;
    end else if (test_se) begin
      cap         <= {cap[33:0], test_si1};
      {lfsr, acc} <= {lfsr[14:0], acc, test_si2};
    end else begin
      cap <= in_bus;
      if (cap[34]) acc <= acc + cap[15:0];
      if (cap[33]) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign out_bus[15:0]  = acc;
  assign out_bus[31:16] = lfsr;
  assign out_bus[46:32] = cap[14:0] ^ cap[29:15];
  assign out_bus[47]    = ^cap;
  assign out_bus[48]    = &acc;
  assign test_so1       = cap[34];
  assign test_so2       = lfsr[15];

  assign {n3110gat, n3109gat, n3108gat, n3107gat, n3106gat, n3105gat, n3104gat} = out_bus[6:0];
  assign {n3117gat, n3116gat, n3115gat, n3114gat, n3113gat, n3112gat, n3111gat} = out_bus[13:7];
  assign {n3124gat, n3123gat, n3122gat, n3121gat, n3120gat, n3119gat, n3118gat} = out_bus[20:14];
  assign {n3131gat, n3130gat, n3129gat, n3128gat, n3127gat, n3126gat, n3125gat} = out_bus[27:21];
  assign {n3138gat, n3137gat, n3136gat, n3135gat, n3134gat, n3133gat, n3132gat} = out_bus[34:28];
  assign {n3145gat, n3144gat, n3143gat, n3142gat, n3141gat, n3140gat, n3139gat} = out_bus[41:35];
  assign {n3152gat, n3151gat, n3150gat, n3149gat, n3148gat, n3147gat, n3146gat} = out_bus[48:42];

endmodule

// File: tb/tb_s5378_bench.sv
// tb/tb_s5378_bench.sv - scoreboard bench for s5378_bench
// Expectations are queued when stimulus is driven and compared #1 after the next rising edge.
module tb_s5378_bench;

  logic clk = 1'b0;
  logic rst, se, si1, si2;
  logic so1, so2;
  logic [34:0] ib;
  logic [48:0] ob;

  typedef struct {
    string       tag;
    logic [50:0] mask;
    logic [50:0] val;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [34:0] m_r;
  logic [15:0] m_a, m_l;

  always #5 clk = ~clk;

  s5378_bench dut (
    .blif_clk_net(clk), .blif_reset_net(rst),
    .n3065gat(ib[0]),  .n3066gat(ib[1]),  .n3067gat(ib[2]),  .n3068gat(ib[3]),
    .n3069gat(ib[4]),  .n3070gat(ib[5]),  .n3071gat(ib[6]),  .n3072gat(ib[7]),
    .n3073gat(ib[8]),  .n3074gat(ib[9]),  .n3075gat(ib[10]), .n3076gat(ib[11]),
    .n3077gat(ib[12]), .n3078gat(ib[13]), .n3079gat(ib[14]), .n3080gat(ib[15]),
    .n3081gat(ib[16]), .n3082gat(ib[17]), .n3083gat(ib[18]), .n3084gat(ib[19]),
    .n3085gat(ib[20]), .n3086gat(ib[21]), .n3087gat(ib[22]), .n3088gat(ib[23]),
    .n3089gat(ib[24]), .n3090gat(ib[25]), .n3091gat(ib[26]), .n3092gat(ib[27]),
    .n3093gat(ib[28]), .n3094gat(ib[29]), .n3095gat(ib[30]), .n3097gat(ib[31]),
    .n3098gat(ib[32]), .n3099gat(ib[33]), .n3100gat(ib[34]),
    .n3104gat(ob[0]),  .n3105gat(ob[1]),  .n3106gat(ob[2]),  .n3107gat(ob[3]),
    .n3108gat(ob[4]),  .n3109gat(ob[5]),  .n3110gat(ob[6]),  .n3111gat(ob[7]),
    .n3112gat(ob[8]),  .n3113gat(ob[9]),  .n3114gat(ob[10]), .n3115gat(ob[11]),
    .n3116gat(ob[12]), .n3117gat(ob[13]), .n3118gat(ob[14]), .n3119gat(ob[15]),
    .n3120gat(ob[16]), .n3121gat(ob[17]), .n3122gat(ob[18]), .n3123gat(ob[19]),
    .n3124gat(ob[20]), .n3125gat(ob[21]), .n3126gat(ob[22]), .n3127gat(ob[23]),
    .n3128gat(ob[24]), .n3129gat(ob[25]), .n3130gat(ob[26]), .n3131gat(ob[27]),
    .n3132gat(ob[28]), .n3133gat(ob[29]), .n3134gat(ob[30]), .n3135gat(ob[31]),
    .n3136gat(ob[32]), .n3137gat(ob[33]), .n3138gat(ob[34]), .n3139gat(ob[35]),
    .n3140gat(ob[36]), .n3141gat(ob[37]), .n3142gat(ob[38]), .n3143gat(ob[39]),
    .n3144gat(ob[40]), .n3145gat(ob[41]), .n3146gat(ob[42]), .n3147gat(ob[43]),
    .n3148gat(ob[44]), .n3149gat(ob[45]), .n3150gat(ob[46]), .n3151gat(ob[47]),
    .n3152gat(ob[48]),
    .test_se(se), .test_si1(si1), .test_si2(si2), .test_so1(so1), .test_so2(so2)
  );

  task automatic check(input string tag, input logic [50:0] obs, input logic [50:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic d1, input logic d2,
                       input logic [34:0] i);
    rst = r; se = s; si1 = d1; si2 = d2; ib = i;
  endtask

  task automatic push(input string tag, input logic [50:0] mask, input logic [50:0] val);
    exp_t e;
    e.tag = tag; e.mask = mask; e.val = val;
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    logic [50:0] obs;
    @(posedge clk);
    #1;
    obs = {so2, so1, ob};
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs & e.mask, e.val & e.mask);
    end
  endtask

  localparam logic [50:0] ALL    = {51{1'b1}};
  localparam logic [50:0] LOW32  = 51'hFFFF_FFFF;
  localparam logic [50:0] RSTVAL = 51'h1_0000;

  task automatic do_reset(input string tag);
    drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), {3'($urandom), 32'($urandom)});
    push(tag, ALL, RSTVAL);
    cycle();
  endtask

  // Reference model of the block, stepped once per edge from the driven inputs.
  task automatic model_edge();
    logic [15:0] na, nl;
    if (rst) begin
      m_r = '0; m_a = 16'h0000; m_l = 16'h0001;
    end else if (se) begin
      m_l = {m_l[14:0], m_a[15]};
      m_a = {m_a[14:0], si2};
      m_r = {m_r[33:0], si1};
    end else begin
      na = m_r[34] ? m_a + m_r[15:0] : m_a;
      nl = m_r[33] ? {m_l[14:0], m_l[15] ^ m_l[13] ^ m_l[12] ^ m_l[10]} : m_l;
      m_r = ib; m_a = na; m_l = nl;
    end
  endtask

  function automatic logic [50:0] model_obs();
    logic [48:0] o;
    o[15:0]  = m_a;
    o[31:16] = m_l;
    o[46:32] = m_r[14:0] ^ m_r[29:15];
    o[47]    = ^m_r;
    o[48]    = (m_a == 16'hFFFF);
    return {m_l[15], m_r[34], o};
  endfunction

  initial begin
    logic [34:0] p;
    logic [31:0] q, c2o;
    logic [50:0] v;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;

    do_reset("reset_any_inputs");

    // Accumulate 5 per edge with one-cycle capture latency
    drive(1'b0, 1'b0, 1'b0, 1'b0, (35'd1 << 34) | 35'h5);
    push("acc_edge1", LOW32, 51'h1_0000); cycle();
    push("acc_edge2", LOW32, 51'h1_0005); cycle();
    push("acc_edge3", LOW32, 51'h1_000A); cycle();

    do_reset("reset_before_wrap");
    drive(1'b0, 1'b0, 1'b0, 1'b0, (35'd1 << 34) | 35'hFFFF);
    push("wrap_edge1", (51'd1 << 48) | 51'hFFFF, 51'h0);               cycle();
    push("wrap_edge2", (51'd1 << 48) | 51'hFFFF, (51'd1 << 48) | 51'hFFFF); cycle();
    push("wrap_edge3", (51'd1 << 48) | 51'hFFFF, 51'hFFFE);             cycle();

    do_reset("reset_before_lfsr");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 35'd1 << 33);
    push("lfsr_edge1", LOW32, 51'h1_0000); cycle();
    push("lfsr_edge2", LOW32, 51'h2_0000); cycle();
    push("lfsr_edge3", LOW32, 51'h4_0000); cycle();

    // Scan: load a known capture pattern, then unload both chains
    do_reset("reset_before_scan");
    p   = 35'h5A5C31E97;
    q   = 32'hC3A5_96E1;
    c2o = 32'h0001_0000;
    drive(1'b0, 1'b0, 1'b0, 1'b0, p);
    push("scan_load_so1", 51'd1 << 49, 51'(p[34]) << 49);
    push("scan_load_acc", LOW32, 51'h1_0000);
    cycle();
    for (int j = 1; j <= 35; j++) begin
      drive(1'b0, 1'b1, 1'b1, (j <= 32) ? q[32 - j] : 1'b0, {3'($urandom), 32'($urandom)});
      push("scan_so1", 51'd1 << 49, (j < 35) ? (51'(p[34 - j]) << 49) : (51'd1 << 49));
      if (j <= 32)
        push("scan_so2", 51'd1 << 50, (j < 32) ? (51'(c2o[31 - j]) << 50) : (51'(q[31]) << 50));
      if (j == 32) push("scan_c2_loaded", LOW32, 51'(q));
      if (j == 35) begin
        push("scan_r_ones_par", (51'h1FFFF) << 32, 51'd1 << 47);
        push("scan_c2_final", LOW32, 51'({q[28:0], 3'b000}));
      end
      cycle();
    end

    // Reset in the middle of a scan, then resume shifting
    repeat (3) begin
      drive(1'b0, 1'b1, 1'($urandom), 1'($urandom), {3'($urandom), 32'($urandom)});
      cycle();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, {3'($urandom), 32'($urandom)});
    push("midscan_reset", ALL, RSTVAL);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, {3'($urandom), 32'($urandom)});
    v = '0; v[0] = 1'b1; v[17] = 1'b1; v[32] = 1'b1; v[47] = 1'b1;
    push("midscan_resume", ALL, v);
    cycle();

    // Mixed random traffic against the reference model
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    model_edge();
    push("rand_reset", ALL, model_obs());
    cycle();
    for (int k = 0; k < 80; k++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
            1'($urandom), {3'($urandom), 32'($urandom)});
      if ($urandom_range(0, 1) == 1) ib[34] = 1'b1;
      model_edge();
      push("rand_cycle", ALL, model_obs());
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
